// File: rtl/seq_alu_pkg.sv
// Opcode and FSM state encodings shared by seq_alu and its bench.
// The divide opcode only executes when SEQ_ALU_DIVU_EN is defined.
package seq_alu_pkg;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_OR   = 4'b0010;
  localparam logic [3:0] ALUC_SLL  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_XOR  = 4'b0101;
  localparam logic [3:0] ALUC_SRL  = 4'b0110;
  localparam logic [3:0] ALUC_SLT  = 4'b0111;
  localparam logic [3:0] ALUC_MUL  = 4'b1000;
  localparam logic [3:0] ALUC_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DIV_RUN = 2'b10
  } state_t;

endpackage

// File: rtl/seq_alu_mul_step.sv
// One combinational shift-add multiply iteration: conditionally accumulate
// the multiplicand, then shift multiplicand left and multiplier right.
module seq_alu_mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0] mplier_next
);

  // Accumulate on multiplier LSB and advance both shift registers.
  always_comb begin
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake and iterative shift-add MUL.
// Define SEQ_ALU_DIVU_EN to add a restoring unsigned divider on opcode 1001.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] mcand, mcand_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [SHW-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0] r_nx;
  logic             done_nx;
  logic             ovf_nx;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_acc, step_mcand, step_mplier;

  assign sum  = a + b;
  assign diff = a - b;
  assign busy = (state != ST_IDLE);
  assign zero = (r == {WIDTH{1'b0}});

  seq_alu_mul_step #(.WIDTH(WIDTH)) u_mul_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (step_acc),
    .mcand_next  (step_mcand),
    .mplier_next (step_mplier)
  );

`ifdef SEQ_ALU_DIVU_EN
  // Restoring divide: acc holds the remainder, mcand the divisor, mplier
  // shifts the dividend out of its MSB while quotient bits enter the LSB.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  // One restoring-divide iteration.
  always_comb begin
    rem_sh   = {acc, mplier[WIDTH-1]};
    div_diff = rem_sh - {1'b0, mcand};
    div_ge   = ~div_diff[WIDTH];
    if (div_ge) begin
      div_rem = div_diff[WIDTH-1:0];
    end else begin
      div_rem = rem_sh[WIDTH-1:0];
    end
    div_quo = {mplier[WIDTH-2:0], div_ge};
  end
`endif

  // Single-cycle result and ADD/SUB signed overflow.
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    alu_ovf = 1'b0;
    case (aluc)
      ALUC_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALUC_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALUC_OR:  alu_res = a | b;
      ALUC_SLL: alu_res = b << a[SHW-1:0];
      ALUC_AND: alu_res = a & b;
      ALUC_XOR: alu_res = a ^ b;
      ALUC_SRL: alu_res = b >> a[SHW-1:0];
      ALUC_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  alu_res = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    cnt_nx    = cnt;
    r_nx      = r;
    ovf_nx    = ovf;
    done_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (aluc == ALUC_MUL) begin
            state_nx  = ST_MUL_RUN;
            acc_nx    = {WIDTH{1'b0}};
            mcand_nx  = a;
            mplier_nx = b;
            cnt_nx    = {SHW{1'b0}};
`ifdef SEQ_ALU_DIVU_EN
          end else if (aluc == ALUC_DIVU) begin
            state_nx  = ST_DIV_RUN;
            acc_nx    = {WIDTH{1'b0}};
            mcand_nx  = b;
            mplier_nx = a;
            cnt_nx    = {SHW{1'b0}};
`endif
          end else begin
            r_nx    = alu_res;
            ovf_nx  = alu_ovf;
            done_nx = 1'b1;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_MUL_RUN: begin
        acc_nx    = step_acc;
        mcand_nx  = step_mcand;
        mplier_nx = step_mplier;
        cnt_nx    = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_nx = ST_IDLE;
          r_nx     = step_acc;
          ovf_nx   = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_MUL_RUN;
        end
      end
`ifdef SEQ_ALU_DIVU_EN
      ST_DIV_RUN: begin
        acc_nx    = div_rem;
        mplier_nx = div_quo;
        cnt_nx    = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_nx = ST_IDLE;
          r_nx     = div_quo;
          ovf_nx   = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_DIV_RUN;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset also aborts any running op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= {WIDTH{1'b0}};
      mcand  <= {WIDTH{1'b0}};
      mplier <= {WIDTH{1'b0}};
      cnt    <= {SHW{1'b0}};
      r      <= {WIDTH{1'b0}};
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      cnt    <= cnt_nx;
      r      <= r_nx;
      done   <= done_nx;
      ovf    <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, monitors
// pop and compare on every done pulse. Covers WIDTH=32 and WIDTH=8 instances.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] r;
    logic        ovf;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start = 1'b0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic [3:0]  aluc = 4'h0;
  logic [31:0] r;
  logic        zero, busy, done, ovf;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic [3:0]  aluc8 = 4'h0;
  logic [7:0]  r8;
  logic        zero8, busy8, done8, ovf8;

  exp_t        q32[$];
  exp_t        q8[$];
  logic [31:0] last_r32 = 32'h0;
  logic [7:0]  last_r8  = 8'h0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .aluc(aluc),
    .r(r), .zero(zero), .busy(busy), .done(done), .ovf(ovf)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .aluc(aluc8),
    .r(r8), .zero(zero8), .busy(busy8), .done(done8), .ovf(ovf8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (done === 1'b1) begin
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done32 actual=1 required=0 r=0x%0h", r);
      end else begin
        e = q32.pop_front();
        chk({e.nm, "_r"}, 64'(r), 64'(e.r));
        chk({e.nm, "_zero"}, 64'(zero), 64'(e.r == 32'h0));
        chk({e.nm, "_ovf"}, 64'(ovf), 64'(e.ovf));
        last_r32 = e.r;
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8 actual=1 required=0 r=0x%0h", r8);
      end else begin
        e = q8.pop_front();
        chk({e.nm, "_r"}, 64'(r8), 64'(e.r[7:0]));
        chk({e.nm, "_zero"}, 64'(zero8), 64'(e.r[7:0] == 8'h0));
        chk({e.nm, "_ovf"}, 64'(ovf8), 64'(e.ovf));
        last_r8 = e.r[7:0];
      end
    end
  end

  task automatic push32(input string nm, input logic [31:0] er, input logic eo);
    exp_t e;
    e.nm = nm; e.r = er; e.ovf = eo;
    q32.push_back(e);
  endtask

  task automatic push8(input string nm, input logic [7:0] er, input logic eo);
    exp_t e;
    e.nm = nm; e.r = {24'h0, er}; e.ovf = eo;
    q8.push_back(e);
  endtask

  // Single-cycle op; called #1 after a posedge, returns #1 after the next.
  task automatic op32(input string nm, input logic [3:0] op, input logic [31:0] aa,
                      input logic [31:0] bb, input logic [31:0] er, input logic eo);
    aluc = op; a = aa; b = bb; start = 1'b1;
    push32(nm, er, eo);
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_done_n1"}, 64'(done), 64'h1);
  endtask

  // Multicycle op with ignored start pulses and operand churn during busy.
  task automatic mc32(input string nm, input logic [3:0] op, input logic [31:0] aa,
                      input logic [31:0] bb, input logic [31:0] er);
    int n;
    aluc = op; a = aa; b = bb; start = 1'b1;
    push32(nm, er, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      chk({nm, "_hold"}, 64'(r), 64'(last_r32));
      start = (n == 3 || n == 9) ? 1'b1 : 1'b0;
      aluc  = ALUC_ADD;
      a     = ~aa;
      b     = ~bb;
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(n), 64'd32);
    chk({nm, "_done_end"}, 64'(done), 64'h1);
  endtask

  task automatic op8(input string nm, input logic [3:0] op, input logic [7:0] aa,
                     input logic [7:0] bb, input logic [7:0] er, input logic eo);
    aluc8 = op; a8 = aa; b8 = bb; start8 = 1'b1;
    push8(nm, er, eo);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({nm, "_done_n1"}, 64'(done8), 64'h1);
  endtask

  task automatic mul8(input string nm, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] er);
    int n;
    aluc8 = ALUC_MUL; a8 = aa; b8 = bb; start8 = 1'b1;
    push8(nm, er, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin
      chk({nm, "_hold"}, 64'(r8), 64'(last_r8));
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'd8);
    chk({nm, "_done_end"}, 64'(done8), 64'h1);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r", 64'(r), 64'h0);
    chk("rst_zero", 64'(zero), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    op32("add_ovf", ALUC_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    op32("sub_zero", ALUC_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    op32("sub_ovf", ALUC_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    op32("slt_true", ALUC_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    op32("slt_false", ALUC_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    op32("sll", ALUC_SLL, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0);
    op32("srl", ALUC_SRL, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0);
    op32("or", ALUC_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0);
    op32("and", ALUC_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0);
    op32("xor", ALUC_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    op32("add_after_ovf", ALUC_ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0);
    op32("unknown_op", 4'b1111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0);
`ifndef SEQ_ALU_DIVU_EN
    op32("divu_disabled", ALUC_DIVU, 32'd100, 32'd7, 32'h0000_0000, 1'b0);
`endif

    op32("pre_mul", ALUC_ADD, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0);
    mc32("mul_ones", ALUC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    op32("b2b_add", ALUC_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0);
    mc32("mul_mid", ALUC_MUL, 32'd12345, 32'd678, 32'h007F_B6F6);
`ifdef SEQ_ALU_DIVU_EN
    mc32("divu", ALUC_DIVU, 32'd100, 32'd7, 32'd14);
    mc32("divu_zero", ALUC_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
`endif

    op8("w8_add_ovf", ALUC_ADD, 8'h7F, 8'h01, 8'h80, 1'b1);
    op8("w8_srl", ALUC_SRL, 8'h09, 8'h80, 8'h40, 1'b0);
    mul8("w8_mul", 8'd16, 8'd17, 8'h10);

    // Abort a MUL with reset while r and ovf hold nonzero values.
    op32("pre_rst", ALUC_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    @(posedge clk); #1;
    aluc = ALUC_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_r", 64'(r), 64'h0);
    chk("midrst_zero", 64'(zero), 64'h1);
    chk("midrst_ovf", 64'(ovf), 64'h0);
    repeat (40) @(posedge clk);
    #1;

    chk("q32_empty", 64'(q32.size()), 64'h0);
    chk("q8_empty", 64'(q8.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU of the multicycle CPU.
- Executes single-cycle logic and arithmetic ops, plus an iterative shift-add multiply.
- Uses a start/busy/done handshake so the control FSM can stall in its EX state until the result is ready.
- Result and zero flag are registered and held stable until the next completed operation.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, 8..64).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A (shift amount source for shifts: a[SHW-1:0]).
- b  in  WIDTH  operand B (shifted value for shifts).
- aluc  in  4  opcode, sampled with start.
- r  out  WIDTH  registered result.
- zero  out  1  1 when r==0.
- busy  out  1  multicycle op in progress.
- done  out  1  one-cycle pulse: r/zero/ovf updated this cycle.
- ovf  out  1  signed overflow of last ADD/SUB; 0 for other ops.

Behaviour:
- Reset (rst=1 at clk edge, overrides everything including a running op):
  - r=0, zero=1, busy=0, done=0, ovf=0, state=IDLE, iteration counter=0.
- Opcodes:
  - 0000 ADD a+b
  - 0001 SUB a-b
  - 0010 OR
  - 0011 SLL b<<a[SHW-1:0]
  - 0100 AND
  - 0101 XOR
  - 0110 SRL b>>a[SHW-1:0] (logical)
  - 0111 SLT signed(a<b) ? 1 : 0, zero-extended
  - 1000 MUL low WIDTH bits of a*b (unsigned/signed identical in low half)
  - 1001 DIVU (optional feature only)
  - All others: result 0, single-cycle.
- All arithmetic is modulo 2^WIDTH. ovf is computed for ADD/SUB only, from operand and result sign bits.
- States: IDLE, MUL_RUN (DIV_RUN when the optional feature is compiled in).
- IDLE, start=1, single-cycle op: result registered at edge N. r, zero, ovf and done=1 are visible in cycle N+1. Stays in IDLE.
- IDLE, start=1, MUL:
  - Latch a and b into internal regs at edge N; go to MUL_RUN; clear accumulator and counter.
  - busy=1 from cycle N+1 through N+WIDTH.
  - One shift-add step per cycle (accumulate multiplicand if multiplier LSB=1; shift multiplicand left, multiplier right).
  - After WIDTH steps: r=accumulator, done=1 in cycle N+WIDTH+1; busy=0 in the same cycle; return to IDLE.
- Throughout a MUL/DIV run, r and zero keep the previous result; they do not change until done.
- start while busy=1 is ignored. aluc, a and b may change freely during a run; the latched copies are used.
- start in the cycle done=1 is accepted (back-to-back ops). done may therefore stay high on consecutive cycles for back-to-back single-cycle ops.
- done is a pulse per completed op, never held otherwise.
- zero is derived from the r register, so it updates exactly with r.
- No operation in flight and start=0: all outputs hold, done=0.

Optional Feature:
- Macro: SEQ_ALU_DIVU_EN.
- Defined:
  - Opcode 1001 runs a restoring unsigned divide in DIV_RUN: WIDTH iterations, same handshake and latency as MUL, r=quotient.
  - Divide by zero gives r = all ones, with the same latency.
- Undefined: 1001 is treated as an unknown opcode (single-cycle, r=0). No divider logic is synthesised.

Decomposition:
- Package seq_alu_pkg holds:
  - the 4-bit opcode constants (ALUC_ADD..ALUC_DIVU);
  - the state encoding constants.
- Sub-module seq_alu_mul_step: one combinational shift-add iteration (acc, mcand, mplier in; next values out). It is instantiated once and reused by the FSM.
- Logic ops stay inline.

Test Plan:
- Reset mid-MUL: start MUL a=3 b=5; assert rst at cycle 4. Next cycle: busy=0, done=0, r=0, zero=1. No done pulse afterwards.
- Single-cycle ops, WIDTH=32:
  - ADD 0x7FFFFFFF+1: r=0x80000000, ovf=1, done at N+1.
  - SUB 5-5: r=0, zero=1.
  - SLT -1<1: r=1.
  - SLL a=4 b=1: r=0x10.
- MUL 0xFFFFFFFF*0xFFFFFFFF: busy high exactly 32 cycles; done at N+33 with r=1. r holds the old value throughout busy.
- Handshake:
  - start pulses with different aluc during busy are ignored.
  - Back-to-back: ADD issued in the MUL done cycle gives done again on the next cycle with the ADD result.
- WIDTH=8: MUL 16*17 gives r=0x10 (wrap), busy 8 cycles. SRL a=9 uses a[2:0]=1.
- SEQ_ALU_DIVU_EN:
  - 100/7 gives r=14 after 32 busy cycles.
  - 5/0 gives r=0xFFFFFFFF.
  - Without the macro, 1001 gives r=0, zero=1, at N+1.
